// File: rtl/shift_rotate_seq.sv
// Sequential shift/rotate unit: SHR, SHRA, SHL, ROR, ROL producing a double-width result.
// Define SHIFT_ROTATE_FAST_EN for a single-cycle barrel path; default build iterates STEP bits per cycle.
module shift_rotate_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                     Clock,
    input  logic                     clear,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [WIDTH-1:0]         zlow,
    output logic [WIDTH-1:0]         zhigh
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] STEP_W = (SW+1)'(STEP);

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [WIDTH-1:0] zlow_q, zlow_d;
    logic [WIDTH-1:0] zhigh_q, zhigh_d;

    logic [SW:0]        step_s;
    logic [SW:0]        cnt_full_s;
    logic [2*WIDTH-1:0] res_s;

    function automatic logic is_illegal(input logic [2:0] op_v);
        return (op_v > OP_ROL);
    endfunction

    // One shift of n positions on the {hi,lo} working pair; returns {hi,lo}.
    function automatic logic [2*WIDTH-1:0] shift_step(
        input logic [2:0]       op_v,
        input logic [WIDTH-1:0] hi_v,
        input logic [WIDTH-1:0] lo_v,
        input logic [SW:0]      n
    );
        logic [2*WIDTH-1:0] cat;
        logic [2*WIDTH-1:0] res;
        cat = {2*WIDTH{1'b0}};
        case (op_v)
            OP_SHL: res = {hi_v, lo_v} << n;
            OP_SHR: begin
                cat = {lo_v, hi_v} >> n;
                res = {cat[WIDTH-1:0], cat[2*WIDTH-1:WIDTH]};
            end
            OP_SHRA: begin
                // lo's MSB stays equal to the original sign bit across iterations
                cat = $signed({lo_v, hi_v}) >>> n;
                res = {cat[WIDTH-1:0], cat[2*WIDTH-1:WIDTH]};
            end
            OP_ROR: begin
                cat = {lo_v, lo_v} >> n;
                res = {{WIDTH{1'b0}}, cat[WIDTH-1:0]};
            end
            OP_ROL: begin
                cat = {lo_v, lo_v} << n;
                res = {{WIDTH{1'b0}}, cat[2*WIDTH-1:WIDTH]};
            end
            default: res = {hi_v, lo_v};
        endcase
        return res;
    endfunction

    // Next-state, datapath and output computation
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        zlow_d     = zlow_q;
        zhigh_d    = zhigh_q;
        step_s     = {(SW+1){1'b0}};
        cnt_full_s = {(SW+1){1'b0}};
        res_s      = {2*WIDTH{1'b0}};
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op;
`ifdef SHIFT_ROTATE_FAST_EN
                    res_s   = shift_step(op, {WIDTH{1'b0}}, a, {1'b0, shamt});
                    hi_d    = res_s[2*WIDTH-1:WIDTH];
                    lo_d    = res_s[WIDTH-1:0];
                    cnt_d   = {SW{1'b0}};
                    state_d = DONE;
`else
                    hi_d = {WIDTH{1'b0}};
                    lo_d = a;
                    if ((shamt == {SW{1'b0}}) || is_illegal(op)) begin
                        cnt_d   = {SW{1'b0}};
                        state_d = DONE;
                    end else begin
                        cnt_d   = shamt;
                        state_d = SHIFT;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if ({1'b0, cnt_q} > STEP_W) begin
                    step_s = STEP_W;
                end else begin
                    step_s = {1'b0, cnt_q};
                end
                res_s      = shift_step(op_q, hi_q, lo_q, step_s);
                hi_d       = res_s[2*WIDTH-1:WIDTH];
                lo_d       = res_s[WIDTH-1:0];
                cnt_full_s = {1'b0, cnt_q} - step_s;
                cnt_d      = cnt_full_s[SW-1:0];
                if (cnt_d == {SW{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = is_illegal(op_q);
                zlow_d  = lo_q;
                zhigh_d = hi_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, working registers and registered outputs
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            lo_q    <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            cnt_q   <= {SW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            zlow_q  <= {WIDTH{1'b0}};
            zhigh_q <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            zlow_q  <= zlow_d;
            zhigh_q <= zhigh_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign zlow  = zlow_q;
    assign zhigh = zhigh_q;

endmodule

// File: doc/shift_rotate_seq.md
SHIFT_ROTATE_SEQ -- requirements
Module: shift_rotate_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; power of two, 8..64.
REQ-002 SHALL have parameter STEP, default 1: maximum bit positions shifted per cycle; power of two, 1..WIDTH.
REQ-003 SHALL have port Clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request; sampled on a rising edge only while busy=0.
REQ-006 SHALL have port op, input, 3: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101..111 illegal.
REQ-007 SHALL have port a, input, WIDTH: operand.
REQ-008 SHALL have port shamt, input, log2(WIDTH): shift amount, 0..WIDTH-1.
REQ-009 SHALL have port busy, output, 1: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1: one-cycle pulse, coincident with done, flagging an illegal op.
REQ-012 SHALL have ports zlow and zhigh, output, WIDTH each: result low and high words.

Function
REQ-013 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE; when shamt=0 or op is illegal, IDLE -> DONE directly.
REQ-014 SHALL latch op, a and shamt on the edge that accepts start; later input changes SHALL NOT affect the running operation.
REQ-015 SHALL shift min(STEP, remaining) positions per SHIFT cycle, decrement the remaining count by that amount, and move to DONE when the count reaches 0.
REQ-016 SHALL assert done for exactly one cycle, beginning ceil(shamt/STEP)+1 rising edges after the accepting edge.
REQ-017 SHALL hold busy=1 in SHIFT and DONE and busy=0 in IDLE; start while busy=1 SHALL be ignored, not queued.
REQ-018 SHALL accept a new start in the cycle immediately after DONE (back-to-back).
REQ-019 SHALL compute SHL as {zhigh,zlow} = {WIDTH'b0,a} << shamt (zhigh receives the bits shifted out).
REQ-020 SHALL compute SHR as {zlow,zhigh} = {a,WIDTH'b0} >> shamt, logical (zhigh receives the shifted-out bits, left-aligned).
REQ-021 SHALL compute SHRA as SHR, except that zlow is filled with a[WIDTH-1].
REQ-022 SHALL compute ROR and ROL as a rotated by shamt in zlow, with zhigh=0.
REQ-023 SHALL, for an illegal op, set zlow=a and zhigh=0 and pulse err together with done.
REQ-024 SHALL hold zlow and zhigh stable from done until the next accepted start; intermediate values during SHIFT are don't-care.

Reset
REQ-025 SHALL, on clear=1 (asynchronous), go to IDLE with busy=0, done=0, err=0, zlow=0, zhigh=0 and remaining count 0.
REQ-026 SHALL abort an in-flight operation on clear without producing done, and accept start on the first edge after clear deasserts.

Configuration
REQ-027 SHALL, with macro SHIFT_ROTATE_FAST_EN defined, use a single-cycle barrel path: SHIFT is never entered, STEP is ignored, and done occurs 1 edge after accept for every shamt.
REQ-028 SHALL, without SHIFT_ROTATE_FAST_EN, use the iterative STEP-per-cycle datapath of REQ-015 and REQ-016; results SHALL be identical in both builds.

Verification
REQ-029 SHALL be verified, with WIDTH=32 and STEP=1, by: SHL a=12, shamt=5 -> zlow=0x00000180, zhigh=0, done 6 edges after accept.
REQ-030 SHALL be verified by: SHR a=0x000000FF, shamt=4 -> zlow=0x0000000F, zhigh=0xF0000000; SHRA a=0xF0000000, shamt=8 -> zlow=0xFFF00000.
REQ-031 SHALL be verified by: ROL a=0x80000001, shamt=4 -> zlow=0x00000018, zhigh=0; shamt=0 on any op -> done 1 edge after accept, zlow=a.
REQ-032 SHALL be verified, with STEP=4, by: SHL a=1, shamt=31 -> done 9 edges after accept, zlow=0x80000000.
REQ-033 SHALL be verified by: clear pulsed 3 cycles into a shamt=20 operation -> no done, outputs 0, busy=0; a new start immediately afterward completes correctly.
REQ-034 SHALL be verified by: op=111 -> err and done pulse together, zlow=a; with SHIFT_ROTATE_FAST_EN, shamt=31 -> done 1 edge after accept.
